game_port: RTL and testbench
============================

GAME_PORT -- requirements
Module: game_port

Interface
REQ-001 NUM_AXES, 4, number of timed axes (1..4).
REQ-002 CNT_W, 9, axis down-counter width in bits.
REQ-003 DIV, 265, prescaler terminal value; a tick occurs every DIV+1 clocks.
REQ-004 CENTER, 200, count loaded for a centred axis.
REQ-005 MIN_CNT, 8; MAX_CNT, 391, counts loaded for digital full deflection.
REQ-006 DEADZONE, 6, analog magnitude treated as centre (used only under GAME_PORT_DEADZONE_EN).
REQ-007 Clocking: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-008 clk  in  1  system clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 ana  in  8*NUM_AXES  signed analog position per axis; axis i occupies [8i+7:8i].
REQ-011 dig  in  2*NUM_AXES  digital direction per axis; bit 2i is toward-min, bit 2i+1 is toward-max; active-high.
REQ-012 btn  in  4  fire buttons, active-high.
REQ-013 write  in  1  port write strobe.
REQ-014 writedata  in  32  write data (ignored).
REQ-015 byteenable  in  4  byte lanes.
REQ-016 readdata  out  32  {16'hFFFF, ~btn_r[3:0], axis_busy[3:0], 8'hFF}.

Function
REQ-017 Trigger: write & byteenable[1] in a cycle; a write without byteenable[1] is ignored.
REQ-018 On trigger, every axis loads its target count and enters TIMING; the prescaler loads 1.
REQ-019 Target when ana[i] != 0: CENTER + v + (v>>>1), computed sign-extended at CNT_W+2 bits and clamped to [1, 2^CNT_W-1].
REQ-020 Target when ana[i] == 0: toward-min set gives MIN_CNT (wins if both bits are set); else toward-max set gives MAX_CNT; else CENTER.
REQ-021 Prescaler counts up each clock; at value DIV it wraps to 0 and issues a tick.
REQ-022 On a tick, each axis with a nonzero count decrements by 1; a count of 0 stays 0 (no wrap).
REQ-023 Axis state machine: IDLE (count 0) to TIMING on trigger; TIMING to IDLE on the tick that reaches 0; trigger in TIMING reloads the count.
REQ-024 axis_busy[i] = (count != 0), registered; bits for i >= NUM_AXES read 0.
REQ-025 A trigger in the same cycle as a tick: the trigger wins, no decrement occurs, and the prescaler loads 1.
REQ-026 btn is registered once; readdata button field lags btn by 1 clock.
REQ-027 Target inputs are sampled only in the trigger cycle; later changes to ana/dig do not affect a running count.

Reset
REQ-028 Reset state: all counts 0, all axes IDLE, prescaler 0, btn_r 0; readdata = 32'hFFFF_F0FF.
REQ-029 rst_n asserted mid-timing aborts the measurement immediately; no tick is pending after release.

Configuration
REQ-030 Macro GAME_PORT_DEADZONE_EN defined: if |ana[i]| <= DEADZONE, the value is treated as 0 and the digital rule (REQ-020) applies.
REQ-031 Macro GAME_PORT_DEADZONE_EN undefined: any nonzero ana[i] uses the analog rule and DEADZONE is unused.

Structure
REQ-032 Package game_port_pkg holds the axis state enum (IDLE, TIMING) and the readdata field offset constants.
REQ-033 Sub-module game_port_axis holds one axis (target calculation, counter, state) and is instantiated NUM_AXES times; the prescaler and button register stay in game_port.

Verification
REQ-034 Reset release -> readdata == 32'hFFFF_F0FF.
REQ-035 Defaults, all inputs centred, trigger -> busy[3:0] = 4'hF; each bit falls exactly 265+199*266 clocks after the trigger.
REQ-036 dig[0]=1 and dig[3]=1, ana=0, trigger -> axis0 loads 8, axis1 loads 391, axes2/3 load 200; axis0 clears first.
REQ-037 ana axis0 = -128 -> target 8; ana axis0 = 127 -> target 390; CENTER=500 with ana=127 -> clamped to 511.
REQ-038 Retrigger at the exact tick cycle with count 5 -> count reloads to target, no decrement, prescaler = 1.
REQ-039 GAME_PORT_DEADZONE_EN with ana=4 and dig toward-max -> target 391; without the macro -> target 206.

Source files
------------

// File: rtl/game_port_pkg.sv
// game_port_pkg: shared axis state type and readdata field offsets for the game port.
package game_port_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    TIMING = 1'b1
  } axis_state_e;

  localparam int RD_LO_LSB   = 0;
  localparam int RD_BUSY_LSB = 8;
  localparam int RD_BTN_LSB  = 12;
  localparam int RD_HI_LSB   = 16;

endpackage

// File: rtl/game_port_if.sv
// game_port_if: host-facing bus of the game port (analog/digital inputs, buttons, write port, readdata).
interface game_port_if #(
  parameter int NUM_AXES = 4
);
  logic [8*NUM_AXES-1:0] ana;
  logic [2*NUM_AXES-1:0] dig;
  logic [3:0]            btn;
  logic                  write;
  logic [31:0]           writedata;
  logic [3:0]            byteenable;
  logic [31:0]           readdata;

  modport master (
    output ana, dig, btn, write, writedata, byteenable,
    input  readdata
  );

  modport slave (
    input  ana, dig, btn, write, writedata, byteenable,
    output readdata
  );
endinterface

// File: rtl/game_port_axis.sv
// game_port_axis: one timed axis -- target count selection, tick-driven down-counter, IDLE/TIMING state.
// Optional macro GAME_PORT_DEADZONE_EN folds small analog magnitudes into the digital rule.
module game_port_axis
  import game_port_pkg::*;
#(
  parameter int CNT_W    = 9,
  parameter int CENTER   = 200,
  parameter int MIN_CNT  = 8,
  parameter int MAX_CNT  = 391,
  parameter int DEADZONE = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             tick,
  input  logic [7:0]       ana,
  input  logic [1:0]       dig,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam int                EXT_W      = CNT_W + 2;
  localparam logic [EXT_W-1:0]  CENTER_EXT = EXT_W'(CENTER);
  localparam logic [CNT_W-1:0]  MAX_T      = '1;

  axis_state_e             state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        target;
  logic                    use_dig;
  logic signed [EXT_W-1:0] v_ext;
  logic signed [EXT_W-1:0] sum;

`ifdef GAME_PORT_DEADZONE_EN
  logic [8:0] mag;
  assign mag     = ana[7] ? (9'd0 - {1'b1, ana}) : {1'b0, ana};
  assign use_dig = (mag <= 9'(DEADZONE));
`else
  logic [8:0] unused_deadzone;
  assign unused_deadzone = 9'(DEADZONE);
  assign use_dig         = (ana == 8'd0);
`endif

  // Analog target is CENTER + 1.5*v, clamped so a running axis never starts at zero.
  always_comb begin
    v_ext  = {{(EXT_W-8){ana[7]}}, ana};
    sum    = $signed(CENTER_EXT) + v_ext + (v_ext >>> 1);
    target = CNT_W'(CENTER);
    if (use_dig) begin
      if (dig[0]) begin
        target = CNT_W'(MIN_CNT);
      end else if (dig[1]) begin
        target = CNT_W'(MAX_CNT);
      end
    end else if (sum[EXT_W-1] || (sum == '0)) begin
      target = CNT_W'(1);
    end else if (|sum[EXT_W-2:CNT_W]) begin
      target = MAX_T;
    end else begin
      target = sum[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          count_d = target;
          state_d = TIMING;
        end
      end
      TIMING: begin
        if (trigger) begin
          count_d = target;
        end else if (tick && (count_q != '0)) begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: rtl/game_port.sv
// game_port: PC-style game port with NUM_AXES one-shot timed axes, shared prescaler and button register.
// Optional macro GAME_PORT_DEADZONE_EN enables the analog deadzone in every axis.
module game_port
  import game_port_pkg::*;
#(
  parameter int NUM_AXES = 4,
  parameter int CNT_W    = 9,
  parameter int DIV      = 265,
  parameter int CENTER   = 200,
  parameter int MIN_CNT  = 8,
  parameter int MAX_CNT  = 391,
  parameter int DEADZONE = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  game_port_if.slave  bus
);

  localparam int PW = $clog2(DIV + 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [3:0]          btn_q, btn_d;
  logic                trigger;
  logic                tick;
  logic [NUM_AXES-1:0] busy_axes;
  logic [3:0]          busy_all;
  logic [31:0]         rd;
  logic                unused_bus;

  assign trigger    = bus.write & bus.byteenable[1];
  assign tick       = (presc_q == PW'(DIV));
  assign unused_bus = ^{bus.writedata, bus.byteenable[3:2], bus.byteenable[0]};

  // A trigger restarts the tick phase so every measurement starts from the same offset.
  always_comb begin
    btn_d = bus.btn;
    if (trigger) begin
      presc_d = PW'(1);
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      btn_q   <= '0;
    end else begin
      presc_q <= presc_d;
      btn_q   <= btn_d;
    end
  end

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic [CNT_W-1:0] axis_count;
    game_port_axis #(
      .CNT_W    (CNT_W),
      .CENTER   (CENTER),
      .MIN_CNT  (MIN_CNT),
      .MAX_CNT  (MAX_CNT),
      .DEADZONE (DEADZONE)
    ) u_axis (
      .clk     (clk),
      .rst_n   (rst_n),
      .trigger (trigger),
      .tick    (tick),
      .ana     (bus.ana[8*i +: 8]),
      .dig     (bus.dig[2*i +: 2]),
      .busy    (busy_axes[i]),
      .count   (axis_count)
    );
  end

  assign busy_all = 4'(busy_axes);

  always_comb begin
    rd                    = '1;
    rd[RD_BTN_LSB  +: 4]  = ~btn_q;
    rd[RD_BUSY_LSB +: 4]  = busy_all;
  end

  assign bus.readdata = rd;

endmodule

// File: tb/tb_game_port.sv
// tb_game_port: directed self-checking bench for game_port (default and CENTER=500 instances).
module tb_game_port;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  game_port_if #(.NUM_AXES(4)) bus   ();
  game_port_if #(.NUM_AXES(4)) bus_c ();

  game_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  game_port #(.CENTER(500)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic trig();
    bus.write      = 1'b1;
    bus.byteenable = 4'b0010;
    step();
    bus.write      = 1'b0;
    bus.byteenable = 4'b0000;
  endtask

  initial begin
    int budget;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ana = '0;   bus.dig = '0;   bus.btn = '0;   bus.write = 1'b0;
    bus.writedata = 32'hDEAD_BEEF;  bus.byteenable = '0;
    bus_c.ana = '0; bus_c.dig = '0; bus_c.btn = '0; bus_c.write = 1'b0;
    bus_c.writedata = '0;           bus_c.byteenable = '0;

    repeat (3) step();
    check("reset_rd", bus.readdata, 32'hFFFF_F0FF);
    check("reset_presc", 32'(dut.presc_q), 32'd0);
    rst_n = 1'b1;
    step();
    check("release_rd", bus.readdata, 32'hFFFF_F0FF);

    // buttons lag one clock
    bus.btn = 4'b0101;
    #1;
    check("btn_before", 32'(bus.readdata[15:12]), 32'hF);
    step();
    check("btn_after", 32'(bus.readdata[15:12]), 32'hA);
    bus.btn = 4'b0000;
    step();

    // write without byteenable[1]
    bus.write = 1'b1; bus.byteenable = 4'b1101;
    step();
    bus.write = 1'b0; bus.byteenable = 4'b0000;
    check("ignored_write", 32'(bus.readdata[11:8]), 32'h0);

    // digital rule: axis0 toward-min, axis1 toward-max
    bus.dig = 8'b0000_1001;
    trig();
    bus.dig = 8'b0000_0000;
    check("dig_cnt0", 32'(dut.g_axis[0].u_axis.count_q), 32'd8);
    check("dig_cnt1", 32'(dut.g_axis[1].u_axis.count_q), 32'd391);
    check("dig_cnt2", 32'(dut.g_axis[2].u_axis.count_q), 32'd200);
    check("dig_cnt3", 32'(dut.g_axis[3].u_axis.count_q), 32'd200);
    check("dig_busy", 32'(bus.readdata[11:8]), 32'hF);
    check("dig_presc", 32'(dut.presc_q), 32'd1);
    repeat (2126) step();
    check("ax0_hold", 32'(bus.readdata[11:8]), 32'hF);
    step();
    check("ax0_clear", 32'(bus.readdata[11:8]), 32'hE);
    check("ax1_run", 32'(dut.g_axis[1].u_axis.count_q), 32'd383);

    // retrigger on the tick cycle with count 5
    bus.dig = 8'b0000_0001;
    trig();
    bus.dig = 8'b0000_0000;
    budget = 0;
    while (!((dut.g_axis[0].u_axis.count_q == 9'd5) && (dut.presc_q == 9'd265)) && budget < 3000) begin
      step();
      budget++;
    end
    check("retrig_wait", 32'(budget < 3000), 32'd1);
    bus.ana = 32'h0000_007F;
    trig();
    check("retrig_cnt0", 32'(dut.g_axis[0].u_axis.count_q), 32'd390);
    check("retrig_cnt1", 32'(dut.g_axis[1].u_axis.count_q), 32'd200);
    check("retrig_presc", 32'(dut.presc_q), 32'd1);

    // analog extremes and digital tie-break
    bus.ana = 32'h0000_0080;
    trig();
    check("ana_m128", 32'(dut.g_axis[0].u_axis.count_q), 32'd8);
    bus.ana = 32'h0000_0004;
    bus.dig = 8'b0011_0010;
    trig();
`ifdef GAME_PORT_DEADZONE_EN
    check("deadzone", 32'(dut.g_axis[0].u_axis.count_q), 32'd391);
`else
    check("deadzone", 32'(dut.g_axis[0].u_axis.count_q), 32'd206);
`endif
    check("both_dig", 32'(dut.g_axis[2].u_axis.count_q), 32'd8);
    bus.ana = 32'h0000_0000;
    bus.dig = 8'b0000_0000;

    // CENTER=500 instance: clamp high, and -128 -> 308
    bus_c.ana = 32'h0000_807F;
    bus_c.write = 1'b1; bus_c.byteenable = 4'b0010;
    step();
    bus_c.write = 1'b0; bus_c.byteenable = 4'b0000;
    check("clamp_hi", 32'(dut_c.g_axis[0].u_axis.count_q), 32'd511);
    check("c500_m128", 32'(dut_c.g_axis[1].u_axis.count_q), 32'd308);

    // reset mid-timing
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("abort_rd", bus.readdata, 32'hFFFF_F0FF);
    check("abort_presc", 32'(dut.presc_q), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("abort_busy", 32'(bus.readdata[11:8]), 32'h0);
    check("abort_cnt0", 32'(dut.g_axis[0].u_axis.count_q), 32'd0);

    // centred full measurement: busy falls 265+199*266 clocks after trigger
    trig();
    check("ctr_busy", 32'(bus.readdata[11:8]), 32'hF);
    repeat (53198) step();
    check("ctr_hold", 32'(bus.readdata[11:8]), 32'hF);
    step();
    check("ctr_clear", 32'(bus.readdata[11:8]), 32'h0);
    check("ctr_rd", bus.readdata, 32'hFFFF_F0FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
